// File: rtl/reset_sequencer.sv
// Debounced, staggered multi-domain reset release with a post-release run window; registered outputs, no backpressure.
// Button edge to debounced level takes 2+DEBOUNCE cycles; channel k releases HOLD-1+k*STAGGER cycles after the first qualifying edge.
module reset_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int DEBOUNCE   = 16,
  parameter int HOLD       = 8,
  parameter int STAGGER    = 4,
  parameter int RUN_CYCLES = 250
) (
  input  logic              i_clk_50mhz,
  input  logic              i_reset_n,
  input  logic              i_btn_n,
  output logic [NUM_CH-1:0] o_rst_n,
  output logic              o_all_released,
  output logic              o_run_done,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DW    = $clog2(DEBOUNCE + 1);
  localparam int CMAX0 = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int CMAX  = (CMAX0 > RUN_CYCLES) ? CMAX0 : RUN_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int KW    = $clog2(NUM_CH + 1);
  localparam int RUN_I = (RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0;

  localparam logic [DW-1:0]     DEB_T  = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]     HOLD_T = CW'(HOLD - 1);
  localparam logic [CW-1:0]     STAG_T = CW'(STAGGER - 1);
  localparam logic [CW-1:0]     RUN_T  = CW'(RUN_I);
  localparam logic [KW-1:0]     LAST_K = KW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE    = NUM_CH'(1);

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            deb;
  logic            deb_nxt;
  logic [DW-1:0]   dcnt;
  logic [DW-1:0]   dcnt_nxt;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   k;

  // deb_nxt drives the FSM so a button press lands on the same edge as the debounce decision.
  always_comb begin
    deb_nxt  = deb;
    dcnt_nxt = '0;
    if (sync2 != deb) begin
      if (dcnt == DEB_T) begin
        deb_nxt = sync2;
      end else begin
        dcnt_nxt = dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_50mhz) begin
    if (!i_reset_n) begin
      state          <= ST_ASSERT;
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      deb            <= 1'b1;
      dcnt           <= '0;
      cnt            <= '0;
      k              <= '0;
      o_rst_n        <= '0;
      o_all_released <= 1'b0;
      o_run_done     <= 1'b0;
    end else begin
      sync1      <= i_btn_n;
      sync2      <= sync1;
      deb        <= deb_nxt;
      dcnt       <= dcnt_nxt;
      o_run_done <= 1'b0;
      if (!deb_nxt) begin
        state          <= ST_ASSERT;
        cnt            <= '0;
        k              <= '0;
        o_rst_n        <= '0;
        o_all_released <= 1'b0;
      end else begin
        case (state)
          ST_ASSERT: begin
            // Hold off counting until the registered level is high too, so release starts cleanly after debounce.
            if (deb) begin
              if (cnt == HOLD_T) begin
                cnt     <= '0;
                o_rst_n <= ONE;
                if (NUM_CH == 1) begin
                  state          <= ST_RUN;
                  o_all_released <= 1'b1;
                end else begin
                  state <= ST_RELEASE;
                  k     <= KW'(1);
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_RELEASE: begin
            if (cnt == STAG_T) begin
              cnt     <= '0;
              o_rst_n <= o_rst_n | (ONE << k);
              if (k == LAST_K) begin
                state          <= ST_RUN;
                o_all_released <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (RUN_CYCLES != 0) begin
              if (cnt == RUN_T) begin
                cnt        <= '0;
                o_run_done <= 1'b1;
                state      <= ST_DONE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised reset/bring-up sequencer for the C5GX RISC-V platform. It sits between the board push-button and `riscv_core_c5gx` and its peripherals.
- Debounces the active-low reset button and stretches reset for a minimum hold time.
- Releases NUM_CH reset domains in a fixed staggered order (core last or first as wired by the integrator).
- Counts a programmable run window after full release and flags its completion. This gives board and sim a deterministic reset sequence and a "run N cycles" marker.

Parameters:
- NUM_CH, 4: number of reset channels, at least 1.
- DEBOUNCE, 16: consecutive stable cycles of the synchronised button level needed to accept a change, at least 1.
- HOLD, 8: cycles all channels stay asserted after reset/button release, at least 1.
- STAGGER, 4: cycles between releases of consecutive channels, at least 1.
- RUN_CYCLES, 250: length of the run window after full release; 0 disables the window.

Ports:
- i_clk_50mhz, input, 1: system clock. Only clock in the block.
- i_reset_n, input, 1: synchronous, active-low block reset.
- i_btn_n, input, 1: raw asynchronous push-button, active low.
- o_rst_n, output, NUM_CH: per-channel active-low reset. Bit k is released k*STAGGER cycles after bit 0.
- o_all_released, output, 1: high while every o_rst_n bit is 1.
- o_run_done, output, 1: single-cycle pulse at the end of the run window.
- o_state, output, 2: 0=ASSERT, 1=RELEASE, 2=RUN, 3=DONE.

Behaviour:
- Reset: i_reset_n sampled 0 at a clock edge gives:
  - state=ASSERT; o_rst_n all 0; o_all_released=0; o_run_done=0.
  - Sync flops=1; debounced button=1 (released); all counters=0.
- i_reset_n has priority over everything, including mid-RELEASE and mid-RUN.
- Button path:
  - 2-flop synchroniser on i_btn_n.
  - Debounce counter increments while the synced value differs from the debounced value, and clears when they match.
  - When the counter reaches DEBOUNCE, the debounced value takes the synced value and the counter clears.
  - Latency from a raw edge to the debounced change is 2+DEBOUNCE cycles.
  - Pulses shorter than DEBOUNCE synced cycles have no effect.
- Debounced button low in any state forces the following on the next edge, and these are held while it stays low:
  - state=ASSERT, o_rst_n all 0, o_all_released=0, counters 0.
- ASSERT state:
  - Cycle counter increments each edge while i_reset_n=1 and the debounced button is high.
  - On the edge where counter==HOLD-1: o_rst_n[0]←1 and counter←0.
  - If NUM_CH==1, go to RUN and set o_all_released←1. Otherwise go to RELEASE.
  - o_rst_n[0] therefore rises on the HOLD-th qualifying edge.
- RELEASE state:
  - Channel index k starts at 1. Counter increments each edge.
  - When counter==STAGGER-1: o_rst_n[k]←1, counter←0, k←k+1.
  - On the edge releasing k==NUM_CH-1, go to RUN and set o_all_released←1 on that same edge.
  - Released bits never re-assert except via ASSERT.
- RUN state:
  - If RUN_CYCLES==0, stay in RUN forever; o_run_done never pulses.
  - Otherwise the counter increments each edge. On counter==RUN_CYCLES-1: o_run_done←1 for exactly one cycle, go to DONE.
- DONE state: outputs hold released; o_run_done=0. Exit only via i_reset_n or a button press.
- Simultaneous events: a debounced button-low on the same edge as a channel release or the run_done edge wins. ASSERT is entered, no release happens, and no pulse is generated.
- Counters are $clog2-sized to their maximum terminal value and never wrap in normal operation.

Test Plan:
Common setup for the scenarios below, unless stated otherwise: NUM_CH=4, HOLD=8, STAGGER=4, DEBOUNCE=16, RUN_CYCLES=20, i_btn_n=1.
- Power-up sequence: hold i_reset_n=0 for 5 edges, then 1. Counting the first edge with i_reset_n=1 as edge 1:
  - o_rst_n = 0001 @8, 0011 @12, 0111 @16, 1111 @20.
  - o_all_released rises @20; o_run_done is high only @40; o_state=3 from @40.
- Glitch rejection: after DONE, drive i_btn_n=0 for 10 cycles. Required: o_rst_n stays 1111, state stays DONE, no pulse.
- Button press: after DONE, drive i_btn_n=0 for 40 cycles. Required:
  - o_rst_n=0000 and state=0 within 18 cycles of the falling edge; held while low.
  - After release, the debounce takes 18 cycles, then the full 8/12/16/20 sequence repeats, with o_run_done 20 cycles after o_all_released.
- Mid-sequence reset: pulse i_reset_n=0 for one edge while o_rst_n=0011. Required: next edge o_rst_n=0000, state=0, then a clean restart with no leftover counts.
- Edge parameters: NUM_CH=1, RUN_CYCLES=0.
  - o_rst_n rises @HOLD together with o_all_released; state goes straight to 2.
  - o_run_done stays 0 for 1000 cycles.
- Simultaneous event: time the debounced button-low to land on edge 20 (the last release). Required: o_rst_n[3] never rises, o_all_released stays 0, state=0.
